band_gain_apply: RTL and testbench
==================================

# band_gain_apply

Downstream stage of the RNN core: consumes the 22 Q16.16 band gains the RNN produces per frame and applies them to the 481-bin complex spectrum. Band gains are linearly interpolated to per-bin gains (eband5ms layout, 4 bins per band unit); each bin is scaled by its gain. Result streams out to the inverse-FFT stage.

## Interface
- `FIXED`, 32: data width, Q16.16 signed.
- `NB_BANDS`, 22: gains per frame.
- `FREQ_SIZE`, 481: bins per frame.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `g_in_valid`  in  1  gain beat valid.
- `g_in_ready`  out  1  gain beat accepted when both high.
- `g_in_data`  in  FIXED  band gain, band 0 first.
- `x_in_valid`  in  1  spectrum bin valid.
- `x_in_ready`  out  1  bin accepted when both high.
- `x_in_re`, `x_in_im`  in  FIXED  bin value, bin 0 first.
- `y_out_valid`  out  1  output bin valid.
- `y_out_ready`  in  1  downstream accepts.
- `y_out_re`, `y_out_im`  out  FIXED  scaled bin.
- `y_out_last`  out  1  high with bin 480.

## Operation
- Band edge table (eband units): 0,1,2,3,4,5,6,7,8,10,12,14,16,20,24,28,34,40,48,60,78,100. Band i covers bins `edge[i]*4` to `edge[i+1]*4 - 1`, size S_i = (edge[i+1]-edge[i])*4, for i = 0..20.
- Reciprocal ROM: RECIP[i] = floor(65536 / S_i).
- Gain load clamp: values < 0 stored as 0; values > 0x00010000 stored as 0x00010000.
- Per-bin gain for bin k in band i, offset j: frac = j*RECIP[i] (Q16.16); g = G[i] + ((frac*(G[i+1]-G[i])) >>> 16). Bins 400..480 use g = 0.
- All products are signed 64-bit; the result is bits [47:16] (arithmetic, truncate toward -inf). y_re = (x_re*g)[47:16], y_im = (x_im*g)[47:16]. No saturation is needed (|g| ≤ 1).
- States:
  - LOAD: g_in_ready=1. Accept gains; cnt 0..21. After the 22nd beat -> PREP.
  - PREP (1 cycle): compute the registered g_cur for bin 0; band=0, j=0 -> RUN.
  - RUN: x_in_ready = !y_out_valid || y_out_ready. On accept:
    - Load the output register from the input and g_cur.
    - Advance j. When j+1 == S_i: band++ and j=0.
    - Compute g_cur for the next bin (registered).
    - After accepting bin 480, y_out_last=1 on that output and the state -> LOAD.
- The next frame's gains may load while the final output is still held. The output register is independent of the gain bank; the gain bank is written only in LOAD.
- g_in_ready=0 and x_in_ready=0 outside LOAD and RUN respectively. Beats offered in the wrong state are not consumed.

## Timing
- Reset values: state=LOAD, g_in_ready=1 (0 while rst high), x_in_ready=0, y_out_valid=0, y_out_re/im=0, y_out_last=0, gain bank=0, counters=0.
- Gain load: 1 beat/cycle. PREP adds 1 cycle, so the first x_in_ready comes ≥23 cycles after the first gain beat with no stalls.
- Latency: bin accepted at edge t -> y_out_valid at t+1. Throughput is 1 bin/cycle when y_out_ready is held high. Frame time is 481 cycles plus stalls.
- Backpressure: while y_out_valid && !y_out_ready, the outputs hold stable, x_in_ready=0, and g_cur/counters are frozen.
- Simultaneous output consume and input accept in one cycle: the register is replaced, with no bubble.
- y_out_valid clears on the cycle after the consume if no new bin is accepted.
- Reset mid-frame: on the next edge all state returns to reset values, and any pending output is dropped (y_out_valid=0).

## Test plan
- All gains 0x00010000, x_re = k<<16, x_im = -(k<<16) -> y equals x for k=0..399; y=0 for k=400..480; y_out_last only on the 481st beat.
- G0=0, G1=0x00010000, others 0, x_re=0x00010000 -> y_re bins 0..3 = 0, 0x4000, 0x8000, 0xC000; bin 4 = 0x00010000 (band 1 start, interpolating toward G2=0).
- Clamp: G0=0xFFFF0000, G1=0x00020000 -> behaves as G0=0, G1=0x00010000 (same outputs as the previous scenario).
- Negative data: all gains 0x00008000, x_re=0xFFFF8000 -> y_re=0xFFFFC000; x_re=0xFFFFFFFF -> y_re=0xFFFFFFFF (floor).
- Backpressure: y_out_ready low for 5 cycles at bin 100 -> y_out held at bin 100, x_in_ready=0, no bin lost or duplicated, 481 outputs total.
- Reset asserted at bin 200 -> next cycle y_out_valid=0, g_in_ready=1; a fresh 22-gain load plus frame produces correct bins from bin 0.

Source files
------------

// File: rtl/band_gain_apply.sv
`default_nettype none
// ============================================================================
//  Module   : band_gain_apply
//  Purpose  : Takes the 22 Q16.16 band gains the RNN produces for one frame,
//             linearly interpolates them to per-bin gains over the 481-bin
//             spectrum (eband5ms layout, 4 bins per band unit) and scales
//             each complex bin by its gain for the inverse-FFT stage.
//  Ports    : clk, rst                    clock, sync active-high reset
//             g_in_valid/ready/data       band gain stream, band 0 first
//             x_in_valid/ready/re/im      spectrum bin stream, bin 0 first
//             y_out_valid/ready/re/im     scaled bin stream
//             y_out_last                  marks bin FREQ_SIZE-1
//  Revision : 1.0  initial release
// ============================================================================
module band_gain_apply #(
   parameter int FIXED     = 32,
   parameter int NB_BANDS  = 22,
   parameter int FREQ_SIZE = 481
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             g_in_valid,
   output logic             g_in_ready,
   input  logic [FIXED-1:0] g_in_data,
   input  logic             x_in_valid,
   output logic             x_in_ready,
   input  logic [FIXED-1:0] x_in_re,
   input  logic [FIXED-1:0] x_in_im,
   output logic             y_out_valid,
   input  logic             y_out_ready,
   output logic [FIXED-1:0] y_out_re,
   output logic [FIXED-1:0] y_out_im,
   output logic             y_out_last
);

   // Products are formed modulo 2^(FIXED+16): only bits [FIXED+15:16] are
   // kept, and the true result always fits, so the upper bits are not needed.
   localparam int             c_PW        = FIXED + 16;
   localparam logic [4:0]     c_GAIN_LAST = 5'(NB_BANDS - 1);
   localparam logic [4:0]     c_BAND_END  = 5'(NB_BANDS - 1);  // first "past the table" band
   localparam logic [8:0]     c_LAST_BIN  = 9'(FREQ_SIZE - 1);
   localparam logic [FIXED-1:0] c_ONE     = {{(FIXED-17){1'b0}}, 1'b1, 16'b0};

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_PREP = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   // Band width in bins, from the edge table 0,1,2,3,4,5,6,7,8,10,12,14,16,
   // 20,24,28,34,40,48,60,78,100 (eband units x 4).
   function automatic logic [6:0] band_size(input logic [4:0] b);
      case (b)
         5'd0, 5'd1, 5'd2, 5'd3,
         5'd4, 5'd5, 5'd6, 5'd7:    band_size = 7'd4;
         5'd8, 5'd9, 5'd10, 5'd11:  band_size = 7'd8;
         5'd12, 5'd13, 5'd14:       band_size = 7'd16;
         5'd15, 5'd16:              band_size = 7'd24;
         5'd17:                     band_size = 7'd32;
         5'd18:                     band_size = 7'd48;
         5'd19:                     band_size = 7'd72;
         5'd20:                     band_size = 7'd88;
         default:                   band_size = 7'd0;
      endcase
   endfunction

   // floor(65536 / band_size)
   function automatic logic [15:0] band_recip(input logic [4:0] b);
      case (b)
         5'd0, 5'd1, 5'd2, 5'd3,
         5'd4, 5'd5, 5'd6, 5'd7:    band_recip = 16'd16384;
         5'd8, 5'd9, 5'd10, 5'd11:  band_recip = 16'd8192;
         5'd12, 5'd13, 5'd14:       band_recip = 16'd4096;
         5'd15, 5'd16:              band_recip = 16'd2730;
         5'd17:                     band_recip = 16'd2048;
         5'd18:                     band_recip = 16'd1365;
         5'd19:                     band_recip = 16'd910;
         5'd20:                     band_recip = 16'd744;
         default:                   band_recip = 16'd0;
      endcase
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic [FIXED-1:0] r_gain [NB_BANDS];
   logic [4:0]       r_cnt;
   logic [4:0]       r_band;
   logic [6:0]       r_j;
   logic [8:0]       r_bin;
   logic [FIXED-1:0] r_g_cur;
   logic             r_y_valid;
   logic [FIXED-1:0] r_y_re;
   logic [FIXED-1:0] r_y_im;
   logic             r_y_last;

   logic             w_g_acc;
   logic             w_x_acc;
   logic             w_last_bin;
   logic [FIXED-1:0] w_g_clamp;
   logic [4:0]       w_band_nxt;
   logic [6:0]       w_j_nxt;
   logic [4:0]       w_q_band;
   logic [6:0]       w_q_j;
   logic [4:0]       w_idx;
   logic [FIXED-1:0] w_gi;
   logic [FIXED-1:0] w_gi1;
   logic [22:0]      w_frac;
   logic signed [FIXED:0]  w_diff;
   logic signed [c_PW-1:0] w_interp;
   logic [FIXED-1:0] w_g_q;
   logic signed [c_PW-1:0] w_prod_re;
   logic signed [c_PW-1:0] w_prod_im;
   logic             w_unused_bits;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_LOAD;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      g_in_ready  = 1'b0;
      x_in_ready  = 1'b0;
      case (r_state)
         S_LOAD: begin
            g_in_ready = !rst;
            if (g_in_valid && !rst && (r_cnt == c_GAIN_LAST))
               w_state_nxt = S_PREP;
         end
         S_PREP: w_state_nxt = S_RUN;
         S_RUN: begin
            x_in_ready = !r_y_valid || y_out_ready;
            if (x_in_valid && (!r_y_valid || y_out_ready) && (r_bin == c_LAST_BIN))
               w_state_nxt = S_LOAD;
         end
         default: w_state_nxt = S_LOAD;
      endcase
   end

   assign w_g_acc    = g_in_valid && g_in_ready;
   assign w_x_acc    = x_in_valid && x_in_ready;
   assign w_last_bin = (r_bin == c_LAST_BIN);

   // Gains are held to [0, 1.0] so interpolation and scaling never overflow.
   always_comb begin
      w_g_clamp = g_in_data;
      if (g_in_data[FIXED-1])      w_g_clamp = '0;
      else if (g_in_data > c_ONE)  w_g_clamp = c_ONE;
   end

   // Position of the bin after the current one. Past the last band the
   // position parks at c_BAND_END, which selects a zero gain.
   always_comb begin
      w_band_nxt = r_band;
      w_j_nxt    = r_j;
      if (r_band < c_BAND_END) begin
         if ((r_j + 7'd1) == band_size(r_band)) begin
            w_band_nxt = r_band + 5'd1;
            w_j_nxt    = 7'd0;
         end else begin
            w_j_nxt = r_j + 7'd1;
         end
      end
   end

   // Gain lookup: PREP asks for bin 0, RUN asks for the next bin.
   assign w_q_band = (r_state == S_PREP) ? 5'd0 : w_band_nxt;
   assign w_q_j    = (r_state == S_PREP) ? 7'd0 : w_j_nxt;
   assign w_idx    = (w_q_band >= c_BAND_END) ? (c_BAND_END - 5'd1) : w_q_band;
   assign w_gi     = r_gain[w_idx];
   assign w_gi1    = r_gain[w_idx + 5'd1];
   assign w_frac   = {16'b0, w_q_j} * {7'b0, band_recip(w_idx)};
   assign w_diff   = $signed({w_gi1[FIXED-1], w_gi1}) - $signed({w_gi[FIXED-1], w_gi});
   assign w_interp = $signed({{(c_PW-23){1'b0}}, w_frac})
                   * $signed({{(c_PW-FIXED-1){w_diff[FIXED]}}, w_diff});
   assign w_g_q    = (w_q_band >= c_BAND_END) ? '0 : (w_gi + w_interp[FIXED+15:16]);

   assign w_prod_re = $signed({{16{x_in_re[FIXED-1]}}, x_in_re})
                    * $signed({{16{r_g_cur[FIXED-1]}}, r_g_cur});
   assign w_prod_im = $signed({{16{x_in_im[FIXED-1]}}, x_in_im})
                    * $signed({{16{r_g_cur[FIXED-1]}}, r_g_cur});

   // Fractional bits discarded by the Q16.16 truncation.
   assign w_unused_bits = ^{w_interp[15:0], w_prod_re[15:0], w_prod_im[15:0]};

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NB_BANDS; i++) r_gain[i] <= '0;
         r_cnt     <= '0;
         r_band    <= '0;
         r_j       <= '0;
         r_bin     <= '0;
         r_g_cur   <= '0;
         r_y_valid <= 1'b0;
         r_y_re    <= '0;
         r_y_im    <= '0;
         r_y_last  <= 1'b0;
      end else begin
         if (w_g_acc) begin
            r_gain[r_cnt] <= w_g_clamp;
            r_cnt         <= (r_cnt == c_GAIN_LAST) ? 5'd0 : (r_cnt + 5'd1);
         end

         if (r_state == S_PREP)
            r_g_cur <= w_g_q;

         if (w_x_acc) begin
            r_y_valid <= 1'b1;
            r_y_re    <= w_prod_re[FIXED+15:16];
            r_y_im    <= w_prod_im[FIXED+15:16];
            r_y_last  <= w_last_bin;
            r_g_cur   <= w_g_q;
            if (w_last_bin) begin
               r_band <= '0;
               r_j    <= '0;
               r_bin  <= '0;
            end else begin
               r_band <= w_band_nxt;
               r_j    <= w_j_nxt;
               r_bin  <= r_bin + 9'd1;
            end
         end else if (y_out_ready) begin
            r_y_valid <= 1'b0;
            r_y_last  <= 1'b0;
         end
      end
   end

   assign y_out_valid = r_y_valid;
   assign y_out_re    = r_y_re;
   assign y_out_im    = r_y_im;
   assign y_out_last  = r_y_last;

endmodule
`default_nettype wire

// File: tb/tb_band_gain_apply.sv
`default_nettype none
// ============================================================================
//  Module   : tb_band_gain_apply
//  Purpose  : Self-checking bench for band_gain_apply. Per-bin gains and
//             scaled outputs are recomputed from the band edge table with
//             plain 64-bit arithmetic and kept in a scoreboard queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_band_gain_apply;

   logic        clk = 1'b0;
   logic        rst;
   logic        g_in_valid, g_in_ready;
   logic [31:0] g_in_data;
   logic        x_in_valid, x_in_ready;
   logic [31:0] x_in_re, x_in_im;
   logic        y_out_valid, y_out_ready;
   logic [31:0] y_out_re, y_out_im;
   logic        y_out_last;

   always #5 clk = ~clk;

   band_gain_apply #(.FIXED(32), .NB_BANDS(22), .FREQ_SIZE(481)) dut (
      .clk         (clk),
      .rst         (rst),
      .g_in_valid  (g_in_valid),
      .g_in_ready  (g_in_ready),
      .g_in_data   (g_in_data),
      .x_in_valid  (x_in_valid),
      .x_in_ready  (x_in_ready),
      .x_in_re     (x_in_re),
      .x_in_im     (x_in_im),
      .y_out_valid (y_out_valid),
      .y_out_ready (y_out_ready),
      .y_out_re    (y_out_re),
      .y_out_im    (y_out_im),
      .y_out_last  (y_out_last)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          EDGE [22] = '{0,1,2,3,4,5,6,7,8,10,12,14,16,20,24,28,34,40,48,60,78,100};
   logic [31:0] g_stim [22];
   longint      gm [22];
   logic [31:0] xr [481];
   logic [31:0] xi [481];
   logic [31:0] got_re [481];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------- reference
   function automatic longint clamp_gain(input logic [31:0] g);
      longint v = longint'($signed(g));
      if (v < 0)     return 0;
      if (v > 65536) return 65536;
      return v;
   endfunction

   function automatic longint model_gain(input int k);
      int     i = 0;
      longint s, rec, j, frac;
      if (k >= EDGE[21] * 4) return 0;
      while (k >= EDGE[i+1] * 4) i++;
      s    = longint'((EDGE[i+1] - EDGE[i]) * 4);
      rec  = 65536 / s;
      j    = longint'(k - EDGE[i] * 4);
      frac = j * rec;
      return gm[i] + ((frac * (gm[i+1] - gm[i])) >>> 16);
   endfunction

   function automatic logic [31:0] model_y(input logic [31:0] x, input longint g);
      longint p = longint'($signed(x)) * g;
      return 32'(p >>> 16);
   endfunction

   // ---------------------------------------------------------- stimulus
   task automatic load_gains(input string tag);
      int i = 0;
      int cyc = 0;
      for (int b = 0; b < 22; b++) gm[b] = clamp_gain(g_stim[b]);
      while (i < 22 && cyc < 200) begin
         @(negedge clk);
         g_in_valid = ($urandom_range(0, 3) != 0);
         g_in_data  = g_stim[i];
         #1;
         if (g_in_valid && g_in_ready) i++;
         cyc++;
      end
      @(negedge clk);
      g_in_valid = 1'b0;
      chk({tag, "_loaded"}, 64'(i), 64'd22);
   endtask

   // bp_mode 0: always ready; 1: 5-cycle stall on bin 100; 2: random.
   // abort_at >= 0 pulses reset when that many outputs have been consumed.
   task automatic run_frame(input string tag, input int bp_mode, input int abort_at);
      int          in_cnt = 0;
      int          out_cnt = 0;
      int          cyc = 0;
      int          stall = 0;
      bit          stall_prev = 0;
      bit          aborted = 0;
      logic [31:0] p_re, p_im;
      logic        p_last;
      logic [31:0] q_re [$];
      logic [31:0] q_im [$];
      logic [31:0] e_re, e_im;
      longint      g;
      while (out_cnt < 481 && cyc < 6000) begin
         @(negedge clk);
         if (abort_at >= 0 && out_cnt == abort_at) begin
            rst        = 1'b1;
            x_in_valid = 1'b0;
            #1;
            chk({tag, "_rst_grdy_hi"}, 64'(g_in_ready), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk({tag, "_rst_yvalid"}, 64'(y_out_valid), 64'd0);
            chk({tag, "_rst_grdy"}, 64'(g_in_ready), 64'd1);
            chk({tag, "_rst_xrdy"}, 64'(x_in_ready), 64'd0);
            aborted = 1;
            break;
         end
         if (stall_prev) begin
            chk({tag, "_hold_v"}, 64'(y_out_valid), 64'd1);
            chk({tag, "_hold_re"}, 64'(y_out_re), 64'(p_re));
            chk({tag, "_hold_im"}, 64'(y_out_im), 64'(p_im));
            chk({tag, "_hold_last"}, 64'(y_out_last), 64'(p_last));
         end
         x_in_valid = (in_cnt < 481) && (bp_mode != 2 || $urandom_range(0, 3) != 0);
         x_in_re    = xr[(in_cnt < 481) ? in_cnt : 0];
         x_in_im    = xi[(in_cnt < 481) ? in_cnt : 0];
         case (bp_mode)
            1: begin
               y_out_ready = !(out_cnt == 100 && stall < 5 && y_out_valid);
               if (!y_out_ready) stall++;
            end
            2:       y_out_ready = ($urandom_range(0, 9) < 7);
            default: y_out_ready = 1'b1;
         endcase
         #1;
         if (y_out_valid && !y_out_ready)
            chk({tag, "_xrdy_stall"}, 64'(x_in_ready), 64'd0);
         if (y_out_valid && y_out_ready) begin
            chk({tag, "_sb_nonempty"}, 64'(q_re.size() > 0), 64'd1);
            if (q_re.size() > 0) begin
               e_re = q_re.pop_front();
               e_im = q_im.pop_front();
               chk({tag, "_re"}, 64'(y_out_re), 64'(e_re));
               chk({tag, "_im"}, 64'(y_out_im), 64'(e_im));
            end
            chk({tag, "_last"}, 64'(y_out_last), 64'(out_cnt == 480));
            got_re[out_cnt] = y_out_re;
            out_cnt++;
         end
         if (x_in_valid && x_in_ready) begin
            g = model_gain(in_cnt);
            q_re.push_back(model_y(xr[in_cnt], g));
            q_im.push_back(model_y(xi[in_cnt], g));
            in_cnt++;
         end
         stall_prev = y_out_valid && !y_out_ready;
         p_re   = y_out_re;
         p_im   = y_out_im;
         p_last = y_out_last;
         cyc++;
      end
      if (!aborted) begin
         chk({tag, "_out_count"}, 64'(out_cnt), 64'd481);
         chk({tag, "_in_count"}, 64'(in_cnt), 64'd481);
      end
      @(negedge clk);
      x_in_valid  = 1'b0;
      y_out_ready = 1'b1;
   endtask

   task automatic rand_setup();
      for (int b = 0; b < 22; b++) g_stim[b] = 32'($urandom_range(0, 32'h14000)) - 32'h2000;
      for (int k = 0; k < 481; k++) begin
         xr[k] = $urandom;
         xi[k] = $urandom;
      end
   endtask

   logic [31:0] interp_exp [5];

   initial begin
      rst         = 1'b1;
      g_in_valid  = 1'b0;
      g_in_data   = '0;
      x_in_valid  = 1'b0;
      x_in_re     = '0;
      x_in_im     = '0;
      y_out_ready = 1'b1;
      interp_exp  = '{32'h0, 32'h4000, 32'h8000, 32'hC000, 32'h10000};

      repeat (2) @(negedge clk);
      #1;
      chk("rst_grdy_low", 64'(g_in_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_grdy", 64'(g_in_ready), 64'd1);
      chk("rst_xrdy", 64'(x_in_ready), 64'd0);
      chk("rst_yvalid", 64'(y_out_valid), 64'd0);
      chk("rst_yre", 64'(y_out_re), 64'd0);
      chk("rst_ylast", 64'(y_out_last), 64'd0);

      // Unity gain: pass-through up to bin 399, zero above.
      for (int b = 0; b < 22; b++) g_stim[b] = 32'h00010000;
      for (int k = 0; k < 481; k++) begin
         xr[k] = 32'(k) << 16;
         xi[k] = -(32'(k) << 16);
      end
      load_gains("unity");
      run_frame("unity", 0, -1);
      chk("unity_b10", 64'(got_re[10]), 64'h000A0000);
      chk("unity_b399", 64'(got_re[399]), 64'h018F0000);
      chk("unity_b400", 64'(got_re[400]), 64'h0);

      // Interpolation across band 0 and clamped equivalent.
      for (int pass = 0; pass < 2; pass++) begin
         for (int b = 0; b < 22; b++) g_stim[b] = 32'h0;
         g_stim[0] = (pass == 0) ? 32'h00000000 : 32'hFFFF0000;
         g_stim[1] = (pass == 0) ? 32'h00010000 : 32'h00020000;
         for (int k = 0; k < 481; k++) begin
            xr[k] = 32'h00010000;
            xi[k] = $urandom;
         end
         load_gains(pass == 0 ? "interp" : "clamp");
         run_frame(pass == 0 ? "interp" : "clamp", 0, -1);
         for (int k = 0; k < 5; k++)
            chk(pass == 0 ? "interp_bin" : "clamp_bin", 64'(got_re[k]), 64'(interp_exp[k]));
      end

      // Negative data truncates toward -inf.
      for (int b = 0; b < 22; b++) g_stim[b] = 32'h00008000;
      for (int k = 0; k < 481; k++) begin
         xr[k] = (k % 2 == 0) ? 32'hFFFF8000 : 32'hFFFFFFFF;
         xi[k] = $urandom;
      end
      load_gains("neg");
      run_frame("neg", 0, -1);
      chk("neg_b0", 64'(got_re[0]), 64'hFFFFC000);
      chk("neg_b1", 64'(got_re[1]), 64'hFFFFFFFF);

      // Backpressure at bin 100, then fully random handshakes.
      rand_setup();
      load_gains("bp");
      run_frame("bp", 1, -1);
      for (int r = 0; r < 2; r++) begin
         rand_setup();
         load_gains("rnd");
         run_frame("rnd", 2, -1);
      end

      // Reset mid-frame, then a clean frame.
      rand_setup();
      load_gains("abort");
      run_frame("abort", 0, 200);
      rand_setup();
      load_gains("after");
      run_frame("after", 2, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
